rr_timeout_arbiter: RTL

RR_TIMEOUT_ARBITER -- requirements
Module: rr_timeout_arbiter

---
 rtl/noc_arb_pkg.sv | 9 +
 rtl/arb_port_timer.sv | 40 ++++
 rtl/rr_timeout_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/noc_arb_pkg.sv
// rtl/noc_arb_pkg.sv - shared constants for the NoC round-robin arbiters
package noc_arb_pkg;

    localparam logic [2:0] HEADER_ID     = 3'b001;
    localparam int         FLIT_ID_W_DEF = 3;
    localparam int         MAX_PORTS     = 16;
    localparam int         PORT_IDX_W    = $clog2(MAX_PORTS);

endpackage

// File: rtl/arb_port_timer.sv
// rtl/arb_port_timer.sv - per-port hold limit and grant-age counter
module arb_port_timer
    import noc_arb_pkg::*;
#(
    parameter int LEN_W     = 12,
    parameter int FLIT_ID_W = FLIT_ID_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [FLIT_ID_W-1:0] i_flit_id,
    input  logic [LEN_W-1:0]     i_length,
    input  logic                 i_grant,
    output logic                 o_expire
);

    logic [LEN_W-1:0] r_limit;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W:0]   w_count_inc;

    assign w_count_inc = {1'b0, r_count} + 1'b1;
    assign o_expire    = i_grant && (r_limit != '0) && (w_count_inc >= {1'b0, r_limit});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_limit <= '0;
            r_count <= '0;
        end else begin
            if (i_flit_id == FLIT_ID_W'(HEADER_ID)) begin
                r_limit <= i_length;
            end
            // An expiring grant is either withdrawn or reissued; both start a fresh count.
            if (i_grant && !o_expire) begin
                r_count <= (r_count == '1) ? r_count : w_count_inc[LEN_W-1:0];
            end else begin
                r_count <= '0;
            end
        end
    end

endmodule

// File: rtl/rr_timeout_arbiter.sv
// rtl/rr_timeout_arbiter.sv - round-robin arbiter with per-port grant timeout
// Timeout logic is present only when RR_TIMEOUT_ARBITER_TIMEOUT_EN is defined.
module rr_timeout_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NPORTS    = 5,
    parameter int LEN_W     = 12,
    parameter int FLIT_ID_W = FLIT_ID_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NPORTS*FLIT_ID_W-1:0] flit_id,
    input  logic [NPORTS*LEN_W-1:0]     length,
    input  logic [NPORTS-1:0]           req,
    output logic [NPORTS-1:0]           grant,
    output logic                        busy,
    output logic [NPORTS-1:0]           timeout
);

    localparam int IDX_W = PORT_IDX_W;

    logic [NPORTS-1:0] r_grant;
    logic              r_busy;
    logic [IDX_W-1:0]  r_last;
    logic [NPORTS-1:0] w_expire;
    logic [NPORTS-1:0] w_grant_nxt;
    logic [IDX_W-1:0]  w_last_nxt;
    logic              w_hold;
    logic [IDX_W:0]    w_pick;

    // Returns {found, index}; distance 0 is the port right after i_last.
    function automatic logic [IDX_W:0] f_rr_pick(input logic [NPORTS-1:0] i_vec,
                                                 input logic [IDX_W-1:0]  i_last);
        logic [IDX_W:0] v_res;
        int             v_best;
        int             v_dist;
        v_res  = '0;
        v_best = NPORTS;
        for (int p = 0; p < NPORTS; p++) begin
            v_dist = (p + NPORTS - 1 - int'(i_last)) % NPORTS;
            if (i_vec[p] && (v_dist < v_best)) begin
                v_best = v_dist;
                v_res  = {1'b1, IDX_W'(p)};
            end
        end
        return v_res;
    endfunction

    always_comb begin
        w_grant_nxt = '0;
        w_last_nxt  = r_last;
        w_hold      = |(r_grant & req & ~w_expire);
        w_pick      = f_rr_pick(req, r_last);
        if (w_hold) begin
            w_grant_nxt = r_grant;
        end else if (w_pick[IDX_W]) begin
            w_grant_nxt = NPORTS'(1) << w_pick[IDX_W-1:0];
            w_last_nxt  = w_pick[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_last  <= IDX_W'(NPORTS - 1);
        end else begin
            r_grant <= w_grant_nxt;
            r_busy  <= |w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;

`ifdef RR_TIMEOUT_ARBITER_TIMEOUT_EN
    logic [NPORTS-1:0] r_timeout;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_timer
        arb_port_timer #(
            .LEN_W     (LEN_W),
            .FLIT_ID_W (FLIT_ID_W)
        ) u_timer (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_flit_id (flit_id[gi*FLIT_ID_W +: FLIT_ID_W]),
            .i_length  (length[gi*LEN_W +: LEN_W]),
            .i_grant   (r_grant[gi]),
            .o_expire  (w_expire[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout <= '0;
        end else begin
            r_timeout <= w_expire;
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{flit_id, length};
    assign w_expire     = '0;
    assign timeout      = '0;
`endif

endmodule
